seq_detect_disp: RTL and testbench

Parametrised serial sequence detector with a built-in step prescaler and a 7-segment display of the current match state.
- Shifts one input bit per prescaled step, recognises a compile-time bit pattern in overlapping or non-overlapping mode, and counts detections.
- Drives active-low segments for the board display and a step indicator LED.
- Sits between the board's debounced switch input and its 7-segment/LED pins, clocked from the fabric system clock.

---
 rtl/seq_detect_pkg.sv | 78 +++++++
 rtl/seq_detect_disp_seg7.sv | 27 ++
 rtl/seq_detect_disp.sv | 102 ++++++++++
 tb/tb_seq_detect_disp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time helpers for the serial sequence detector.
// The next-state table is built here once per pattern; no pattern storage exists at runtime.
`timescale 1ns/1ps
package seq_detect_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned PAT_W   = 9;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Indexed [state][input bit]; entries beyond PATTERN_LEN-1 stay zero.
    typedef logic [15:0][1:0][STATE_W-1:0] next_tbl_t;

    function automatic logic pat_bit(input logic [PAT_W-1:0] pattern, input int idx);
        logic [PAT_W-1:0] sh;
        sh = pattern >> idx;
        return sh[0];
    endfunction

    // Prefix bit i (received order) is pattern[len-1-i]. The string examined is the
    // s-bit matched prefix followed by b; the result is the longest pattern prefix
    // that ends it, capped below len so a full match is never held.
    function automatic logic [STATE_W-1:0] kmp_next(input logic [PAT_W-1:0] pattern,
                                                    input int len, input int s,
                                                    input logic b, input logic overlap);
        logic [STATE_W-1:0] nxt;
        logic               found;
        logic               ok;
        logic               exp_b;
        logic               t_b;
        int                 i;
        nxt   = '0;
        found = 1'b0;
        exp_b = pat_bit(pattern, len - 1 - s);
        if (b == exp_b && s + 1 < len) begin
            nxt   = STATE_W'(s + 1);
            found = 1'b1;
        end else if (b == exp_b && !overlap) begin
            found = 1'b1;
        end
        for (int k = s; k > 0; k--) begin
            if (!found) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    i   = s + 1 - k + j;
                    t_b = (i < s) ? pat_bit(pattern, len - 1 - i) : b;
                    if (t_b != pat_bit(pattern, len - 1 - j)) ok = 1'b0;
                end
                if (ok) begin
                    nxt   = STATE_W'(k);
                    found = 1'b1;
                end
            end
        end
        return nxt;
    endfunction

    function automatic next_tbl_t kmp_table(input logic [PAT_W-1:0] pattern, input int len,
                                            input logic overlap);
        next_tbl_t tbl;
        tbl = '0;
        for (int s = 0; s < len; s++) begin
            tbl[4'(s)][0] = kmp_next(pattern, len, s, 1'b0, overlap);
            tbl[4'(s)][1] = kmp_next(pattern, len, s, 1'b1, overlap);
        end
        return tbl;
    endfunction

endpackage

// File: rtl/seq_detect_disp_seg7.sv
// Combinational 4-bit value to active-low {a,b,c,d,e,f,g} segment pattern.
// Only digits 0..8 have glyphs; every other code blanks the display.
`timescale 1ns/1ps
module seg7_decode
    import seq_detect_pkg::*;
(
    input  logic [STATE_W-1:0] digit_i,
    output logic [6:0]         seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seq_detect_disp.sv
// Serial pattern detector advanced by a clock prescaler, with detect flag, decimal hit
// counter, step LED and registered 7-segment views of the match state and hit count.
`timescale 1ns/1ps
module seq_detect_disp
    import seq_detect_pkg::*;
#(
    parameter int unsigned      PATTERN_LEN = 4,
    parameter logic [PAT_W-1:0] PATTERN     = 9'b0_0000_1011,
    parameter bit               OVERLAP     = 1'b1,
    parameter int unsigned      DIV         = 40000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    output logic               y,
    output logic               step_led,
    output logic [STATE_W-1:0] state,
    output logic [3:0]         hit_cnt,
    output logic [6:0]         seg,
    output logic [6:0]         hit_seg
);

    if (PATTERN_LEN < 2 || PATTERN_LEN > 9) begin : g_len_check
        $error("seq_detect_disp: PATTERN_LEN must be in 2..9");
    end
    if (DIV < 1) begin : g_div_check
        $error("seq_detect_disp: DIV must be at least 1");
    end

    localparam int unsigned        CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [STATE_W-1:0] LAST_S   = STATE_W'(PATTERN_LEN - 1);
    localparam next_tbl_t          NEXT_TBL = kmp_table(PATTERN, int'(PATTERN_LEN), OVERLAP);

    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [3:0]         hit_q, hit_d;
    logic               y_q, y_d;
    logic               led_q, led_d;
    logic [6:0]         seg_q, seg_d;
    logic [6:0]         hit_seg_q, hit_seg_d;
    logic               step;
    logic               match;

    assign step  = (div_cnt_q == DIV_LAST);
    assign match = step && (state_q == LAST_S) && (x == PATTERN[0]);

    always_comb begin
        div_cnt_d = step ? '0 : div_cnt_q + 1'b1;
        state_d   = state_q;
        hit_d     = hit_q;
        y_d       = y_q;
        led_d     = led_q;
        if (step) begin
            state_d = NEXT_TBL[state_q][x];
            y_d     = match;
            led_d   = ~led_q;
            if (match) begin
                hit_d = (hit_q == 4'd9) ? 4'd0 : hit_q + 4'd1;
            end
        end
    end

    // Decode from next-state so the registered glyphs never lag the values they show.
    seg7_decode u_state_seg (
        .digit_i (state_d),
        .seg_o   (seg_d)
    );

    seg7_decode u_hit_seg (
        .digit_i (hit_d),
        .seg_o   (hit_seg_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            state_q   <= '0;
            hit_q     <= '0;
            y_q       <= 1'b0;
            led_q     <= 1'b0;
            seg_q     <= SEG_0;
            hit_seg_q <= SEG_0;
        end else begin
            div_cnt_q <= div_cnt_d;
            state_q   <= state_d;
            hit_q     <= hit_d;
            y_q       <= y_d;
            led_q     <= led_d;
            seg_q     <= seg_d;
            hit_seg_q <= hit_seg_d;
        end
    end

    assign y        = y_q;
    assign step_led = led_q;
    assign state    = state_q;
    assign hit_cnt  = hit_q;
    assign seg      = seg_q;
    assign hit_seg  = hit_seg_q;

endmodule

// File: tb/tb_seq_detect_disp.sv
// Scoreboard bench: five detector configurations share one stimulus stream; a stream-level
// reference model queues expected outputs per step and per-instance monitors compare them.
`timescale 1ns/1ps
module tb_seq_detect_disp;

    logic clk = 1'b0;
    logic rst;
    logic x;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic bit_at(input logic [15:0] v, input int i);
        logic [15:0] sh;
        sh = v >> i;
        return sh[0];
    endfunction

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            default: return 7'b1111111;
        endcase
    endfunction

    // hist[0] is the newest received bit; the pattern's first bit is pat[len-1].
    function automatic logic ref_match(input logic [15:0] pat, input int len,
                                       input logic [15:0] hist, input int hcnt);
        if (hcnt < len) return 1'b0;
        for (int i = 0; i < len; i++) begin
            if (bit_at(hist, i) != bit_at(pat, i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Longest pattern prefix shorter than len that ends the received stream.
    function automatic int ref_state(input logic [15:0] pat, input int len,
                                     input logic [15:0] hist, input int hcnt);
        int  best;
        logic ok;
        best = 0;
        for (int k = 1; k < len; k++) begin
            if (k <= hcnt) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (bit_at(hist, k - 1 - j) != bit_at(pat, len - 1 - j)) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    function automatic logic [23:0] pack_out(input logic [3:0] st, input logic yy,
                                             input logic [3:0] hc, input logic led,
                                             input logic [6:0] sg, input logic [6:0] hs);
        return {st, yy, hc, led, sg, hs};
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int         L = (g == 2) ? 2 : (g == 4) ? 9 : 4;
        localparam logic [8:0] P = (g == 2) ? 9'b0_0000_0011 :
                                   (g == 3) ? 9'b0_0000_1001 :
                                   (g == 4) ? 9'b1_1111_1111 : 9'b0_0000_1011;
        localparam bit         O = !(g == 1 || g == 4);
        localparam int         D = (g == 3) ? 4 : (g == 4) ? 5 : 1;

        logic       y_w, led_w;
        logic [3:0] st_w, hc_w;
        logic [6:0] seg_w, hseg_w;

        seq_detect_disp #(
            .PATTERN_LEN (L),
            .PATTERN     (P),
            .OVERLAP     (O),
            .DIV         (D)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .x        (x),
            .y        (y_w),
            .step_led (led_w),
            .state    (st_w),
            .hit_cnt  (hc_w),
            .seg      (seg_w),
            .hit_seg  (hseg_w)
        );

        logic [23:0] exp_q[$];
        logic [15:0] hist;
        int          hcnt, ncyc, hits, m_st;
        logic        m_y, m_led, rst_edge, prev_led;
        bit          started = 1'b0;
        logic [23:0] last, act, e;

        // Reference: steps land every D cycles after reset release.
        always @(posedge clk) begin
            rst_edge = rst;
            if (rst) begin
                hist  = '0;
                hcnt  = 0;
                ncyc  = 0;
                hits  = 0;
                m_led = 1'b0;
                exp_q.delete();
            end else begin
                ncyc++;
                if (ncyc % D == 0) begin
                    hist = {hist[14:0], x};
                    if (hcnt < 16) hcnt++;
                    m_y = ref_match(16'(P), L, hist, hcnt);
                    if (m_y) begin
                        hits = (hits + 1) % 10;
                        if (!O) begin
                            hist = '0;
                            hcnt = 0;
                        end
                    end
                    m_st  = ref_state(16'(P), L, hist, hcnt);
                    m_led = ~m_led;
                    exp_q.push_back(pack_out(4'(m_st), m_y, 4'(hits), m_led,
                                             seg_of(m_st), seg_of(hits)));
                end
            end
        end

        always @(negedge clk) begin
            act = pack_out(st_w, y_w, hc_w, led_w, seg_w, hseg_w);
            if (rst_edge) begin
                e = pack_out(4'd0, 1'b0, 4'd0, 1'b0, 7'b0000001, 7'b0000001);
                check($sformatf("g%0d reset", g), 32'(act), 32'(e));
                last     = e;
                prev_led = 1'b0;
                started  = 1'b1;
            end else if (started) begin
                if (led_w != prev_led) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("g%0d unexpected_step", g), 32'(act), 32'(last));
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("g%0d step", g), 32'(act), 32'(e));
                        last = e;
                    end
                end else begin
                    check($sformatf("g%0d hold", g), 32'(act), 32'(last));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("g%0d missing_step", g), 32'(act), 32'(e));
                        last = e;
                    end
                end
                prev_led = led_w;
            end
        end
    end

    logic [6:0] stream1 = 7'b1011011;

    initial begin
        rst = 1'b1;
        x   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Pattern 1011 overlapping vs restart, plus DIV=4 first-step timing.
        for (int i = 0; i < 7; i++) begin
            x = stream1[6 - i];
            @(negedge clk);
            if (i == 2) check("g3 led_before_first_step", 32'(g_dut[3].led_w), 32'd0);
            if (i == 3) check("g3 led_first_step", 32'(g_dut[3].led_w), 32'd1);
        end
        check("g0 state_after_7", 32'(g_dut[0].st_w), 32'd1);
        check("g0 hits_after_7", 32'(g_dut[0].hc_w), 32'd2);
        check("g0 y_after_7", 32'(g_dut[0].y_w), 32'd1);
        check("g1 state_after_7", 32'(g_dut[1].st_w), 32'd1);
        check("g1 hits_after_7", 32'(g_dut[1].hc_w), 32'd1);
        check("g1 y_after_7", 32'(g_dut[1].y_w), 32'd0);

        // Twelve ones on pattern 11: hit count runs through 9 and wraps to 1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        x   = 1'b1;
        repeat (12) @(negedge clk);
        check("g2 hits_after_12_ones", 32'(g_dut[2].hc_w), 32'd1);
        check("g2 y_after_12_ones", 32'(g_dut[2].y_w), 32'd1);
        check("g2 state_after_12_ones", 32'(g_dut[2].st_w), 32'd1);

        // Reset in the middle of a partial match.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = stream1[6 - i];
            @(negedge clk);
        end
        check("g0 state_mid_pattern", 32'(g_dut[0].st_w), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("g0 state_after_reset", 32'(g_dut[0].st_w), 32'd0);
        check("g0 hits_after_reset", 32'(g_dut[0].hc_w), 32'd0);
        check("g0 y_after_reset", 32'(g_dut[0].y_w), 32'd0);

        // Random phase: uniform bits, then ones-heavy to reach long prefixes.
        for (int i = 0; i < 4000; i++) begin
            if (i < 2000) x = 1'($urandom_range(0, 1));
            else          x = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
